// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forward selects
// and the destination-scoreboard entry mirrored from the EX/WB buffers.
package pipe_ctrl_pkg;

    // Widest register index the scoreboard can hold; narrower indices are zero-extended.
    localparam int SB_RD_W = 8;

    typedef enum logic [1:0] {
        RUN            = 2'b00,
        MC_WAIT        = 2'b01,
        MC_ERR_RECOVER = 2'b10
    } ctrl_state_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_EX = 2'b01,
        FWD_WB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic [SB_RD_W-1:0] rd;
        logic               wr;
        logic               ld;
    } sb_entry_t;

    // x0 is hardwired, so it never produces a dependency.
    function automatic logic sb_match(input logic [SB_RD_W-1:0] rd, input logic wr,
                                      input logic [SB_RD_W-1:0] idx);
        return wr && (idx != '0) && (rd == idx);
    endfunction

endpackage

// File: rtl/hazard_fwd_cmp.sv
// Per-operand dependency check against the EX and WB scoreboard entries:
// picks the forward source and flags a load-use hit on the EX entry.
module hazard_fwd_cmp
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0]  src,
    input  logic               used,
    input  sb_entry_t          ex_ent,
    input  logic [SB_RD_W-1:0] wb_rd,
    input  logic               wb_wr,
    output fwd_sel_e           fwd,
    output logic               load_hit
);

    logic [SB_RD_W-1:0] idx;
    logic               ex_hit;
    logic               wb_hit;

    assign idx      = SB_RD_W'(src);
    assign ex_hit   = used && sb_match(ex_ent.rd, ex_ent.wr, idx);
    assign wb_hit   = used && sb_match(wb_rd, wb_wr, idx);
    assign load_hit = ex_hit && ex_ent.ld;

    // The younger EX result wins over WB.
    always_comb begin
        fwd = FWD_RF;
        if (ex_hit) begin
            fwd = FWD_EX;
        end else if (wb_hit) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller with EX/WB destination scoreboard and a
// multi-cycle EX sequencer guarded by a timeout watchdog.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = $clog2(MC_TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_wr,
    input  logic              id_is_load,
    input  logic              id_is_mc,
    input  logic              mc_done,
    input  logic              ex_br_taken,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              ex_en,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mc_start,
    output logic              mc_err,
    output logic [1:0]        ctrl_state
);

    ctrl_state_e        state_reg, state_next;
    sb_entry_t          ex_reg, ex_next;
    logic [SB_RD_W-1:0] wb_rd_reg;
    logic               wb_wr_reg;
    logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_inc;
    logic               err_reg, err_next;

    logic [REG_AW-1:0]  src_idx  [2];
    logic               src_used [2];
    fwd_sel_e           src_fwd  [2];
    logic               src_ld   [2];
    logic               load_use;

    logic pc_en_c, ifid_en_c, ifid_flush_c, idex_flush_c, ex_en_c, mc_start_c;

    assign src_idx[0]  = id_rs1;
    assign src_idx[1]  = id_rs2;
    assign src_used[0] = id_rs1_used;
    assign src_used[1] = id_rs2_used;

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        hazard_fwd_cmp #(.REG_AW(REG_AW)) u_cmp (
            .src      (src_idx[gi]),
            .used     (src_used[gi]),
            .ex_ent   (ex_reg),
            .wb_rd    (wb_rd_reg),
            .wb_wr    (wb_wr_reg),
            .fwd      (src_fwd[gi]),
            .load_hit (src_ld[gi])
        );
    end

    assign load_use = src_ld[0] | src_ld[1];
    assign cnt_inc  = cnt_reg + CNT_W'(1);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        err_next     = err_reg;
        pc_en_c      = 1'b1;
        ifid_en_c    = 1'b1;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        ex_en_c      = 1'b1;
        mc_start_c   = 1'b0;
        case (state_reg)
            RUN: begin
                if (ex_br_taken) begin
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                end else if (load_use) begin
                    pc_en_c      = 1'b0;
                    ifid_en_c    = 1'b0;
                    idex_flush_c = 1'b1;
                end else if (id_is_mc) begin
                    mc_start_c = 1'b1;
                    cnt_next   = '0;
                    state_next = MC_WAIT;
                end
            end
            MC_WAIT: begin
                pc_en_c   = 1'b0;
                ifid_en_c = 1'b0;
                ex_en_c   = 1'b0;
                cnt_next  = cnt_inc;
                if (mc_done) begin
                    ex_en_c    = 1'b1;
                    state_next = RUN;
                end else if (cnt_inc == CNT_W'(MC_TIMEOUT)) begin
                    err_next   = 1'b1;
                    state_next = MC_ERR_RECOVER;
                end
            end
            MC_ERR_RECOVER: begin
                // Hold fetch/decode while the killed mc op is replaced by a bubble.
                pc_en_c      = 1'b0;
                ifid_en_c    = 1'b0;
                idex_flush_c = 1'b1;
                state_next   = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        ex_next    = '0;
        ex_next.rd = SB_RD_W'(id_rd);
        ex_next.wr = id_reg_wr & ~idex_flush_c;
        ex_next.ld = id_is_load & ~idex_flush_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
            ex_reg    <= '0;
            wb_rd_reg <= '0;
            wb_wr_reg <= 1'b0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            if (ex_en_c) begin
                ex_reg    <= ex_next;
                wb_rd_reg <= ex_reg.rd;
                wb_wr_reg <= ex_reg.wr;
            end
        end
    end

    // Outputs are forced to their idle values for as long as reset is held.
    assign pc_en      = pc_en_c | rst;
    assign ifid_en    = ifid_en_c | rst;
    assign ex_en      = ex_en_c | rst;
    assign ifid_flush = ifid_flush_c & ~rst;
    assign idex_flush = idex_flush_c & ~rst;
    assign mc_start   = mc_start_c & ~rst;
    assign fwd_a      = rst ? 2'b00 : src_fwd[0];
    assign fwd_b      = rst ? 2'b00 : src_fwd[1];
    assign mc_err     = err_reg;
    assign ctrl_state = state_reg;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/forward controller for the pipeline buffers: IF, ID, EX and WB stages, with ALU result buffers at EX and WB.
- Keeps a two-entry destination scoreboard that mirrors the EX and WB buffers.
- Produces forwarding selects, buffer enables and bubble/flush controls.
- Sequences multi-cycle EX operations with a timeout watchdog.

Parameters:
- REG_AW, 5, register-index width.
- MC_TIMEOUT, 64, maximum cycles spent in MC_WAIT before forced abort.
- CNT_W, $clog2(MC_TIMEOUT+1), width of the watchdog counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- id_rs1  in  REG_AW  ID source 1 index.
- id_rs2  in  REG_AW  ID source 2 index.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- id_rd  in  REG_AW  ID destination index.
- id_reg_wr  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- id_is_mc  in  1  ID instruction is a multi-cycle op.
- mc_done  in  1  multi-cycle unit finished; 1-cycle pulse.
- ex_br_taken  in  1  branch/jump in EX resolved taken.
- pc_en  out  1  PC register enable.
- ifid_en  out  1  IF/ID buffer enable.
- ifid_flush  out  1  IF/ID buffer loads bubble.
- idex_flush  out  1  ID/EX buffer loads bubble.
- ex_en  out  1  EX and WB buffer enable (alu buffers hold when 0).
- fwd_a  out  2  rs1 operand source: 00 regfile, 01 EX buffer, 10 WB buffer.
- fwd_b  out  2  rs2 operand source, same encoding.
- mc_start  out  1  1-cycle start pulse to the multi-cycle unit.
- mc_err  out  1  sticky watchdog error.
- ctrl_state  out  2  current FSM state, for debug.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - State = RUN; scoreboard cleared (ex_wr=ex_ld=wb_wr=0, rd fields 0); counter 0; mc_err=0; mc_start=0.
  - Outputs during reset: pc_en=ifid_en=ex_en=1, flushes 0, fwd 00.
- Reset mid-MC_WAIT aborts to RUN without asserting mc_err.
- Scoreboard, updated only when ex_en=1:
  - EX entry <= {id_rd, id_reg_wr & ~idex_flush, id_is_load & ~idex_flush}.
  - WB entry <= EX entry.
- Matching rule: index 0 never matches; a match requires the entry's wr bit = 1.
- Forwarding (combinational, all states): for each used source, EX match -> 01, else WB match -> 10, else 00. EX has priority over WB.
- Load-use hazard: EX entry is a load and matches any used ID source.
- States:
  - RUN=00, MC_WAIT=01, MC_ERR_RECOVER=10. Encoding 11 is unreachable and recovers to RUN.
- RUN, decided in priority order:
  1. ex_br_taken: ifid_flush=1, idex_flush=1, pc_en=1, ifid_en=1. Suppresses hazard and mc handling in the same cycle.
  2. Load-use: pc_en=0, ifid_en=0, idex_flush=1. Exactly one bubble; the next cycle sees the load in WB (fwd 10).
  3. id_is_mc: mc_start=1 for one cycle, instruction advances into EX, counter cleared, next state MC_WAIT.
  4. Otherwise all enables 1, flushes 0.
- MC_WAIT:
  - pc_en=ifid_en=ex_en=0, flushes 0; counter increments each cycle.
  - mc_done=1 -> next state RUN with ex_en=1 that cycle, so the result advances to WB.
  - mc_done is ignored outside MC_WAIT.
  - Counter reaches MC_TIMEOUT without mc_done -> mc_err<=1, next state MC_ERR_RECOVER.
  - ex_br_taken is ignored in MC_WAIT.
- MC_ERR_RECOVER: one cycle with idex_flush=1, ex_en=1 (mc instruction killed, EX entry cleared), then RUN.
- Latency: mc_start is asserted in the same cycle id_is_mc is seen in RUN; total stall = cycles until mc_done.

Decomposition:
- Package pipe_ctrl_pkg: state enum (RUN, MC_WAIT, MC_ERR_RECOVER), fwd_sel enum (FWD_RF=00, FWD_EX=01, FWD_WB=10), scoreboard-entry struct {rd, wr, ld}.
- One sub-module, hazard_fwd_cmp: purely combinational match/forward logic per source operand, instantiated twice.

Test Plan:
- Back-to-back ALU dependency: EX writes x5, ID reads rs1=x5 -> fwd_a=01, no stall; one cycle later fwd_a=10.
- Load-use: load to x7 in EX, ID reads rs2=x7 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle fwd_b=10, pc_en=1. A source of x0 never stalls.
- Branch priority: ex_br_taken=1 together with a load-use condition -> ifid_flush=idex_flush=1, pc_en=1, no stall.
- Multi-cycle op: id_is_mc=1 -> mc_start pulse; mc_done after 10 cycles -> 10 cycles with pc_en=ex_en=0, then RUN; mc_err stays 0.
- Timeout: with MC_TIMEOUT=8 and mc_done never asserted -> mc_err=1 after 8 cycles; one MC_ERR_RECOVER cycle with idex_flush=1; RUN; mc_err stays 1.
- Async reset asserted mid-MC_WAIT, off a clock edge -> outputs immediately at reset values, ctrl_state=00.
